uart_buffered: RTL and testbench
================================

Name: uart_buffered

Overview:
Parametrised successor to the fixed 8N1/8E1 UART top level. Full-duplex UART with its own TX and RX engines, generic data width, a runtime-programmable baud divider, and TX/RX FIFOs. RX words carry per-word parity and framing error flags. It sits between the host register interface and the board serial pins.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), sent LSB first
FIFO_DEPTH, 16, entries per FIFO (power of two, >=2)
DIVIDER_W, 16, width of clock_divider_i

Ports:
clock_i  in  1  system clock
reset_i  in  1  synchronous, active-high reset
clock_divider_i  in  DIVIDER_W  clock cycles per bit; values <4 treated as 4
two_stop_bits_i  in  1  1 = two stop bits (TX only; RX checks the first stop bit)
parity_bit_i  in  1  1 = parity bit present
parity_even_i  in  1  1 = even parity, 0 = odd
write_i  in  1  push data_i into the TX FIFO
data_i  in  DATA_BITS  TX data
read_i  in  1  pop the RX FIFO head
clear_errors_i  in  1  clear the sticky overflow flags
serial_i  in  1  RX line (asynchronous)
serial_o  out  1  TX line
data_o  out  DATA_BITS  RX FIFO head (show-ahead)
parity_err_o  out  1  parity error of the head word
frame_err_o  out  1  framing error of the head word
ready_o  out  1  RX FIFO not empty
tx_full_o  out  1  TX FIFO full
busy_o  out  1  TX FIFO not empty or TX frame in progress
tx_overflow_o  out  1  sticky: write_i dropped because the TX FIFO was full
rx_overrun_o  out  1  sticky: received word dropped because the RX FIFO was full

Behaviour:
- Reset (synchronous, active-high, clock_i only):
  - serial_o=1; all other outputs 0; data_o=0.
  - Both FIFOs emptied; both engines return to IDLE. A frame in flight is abandoned and the line returns high the next cycle.
- Config sampling: divider, parity and stop settings are captured at frame start and held for the whole frame. Changing them mid-frame has no effect until the next frame.
- FIFOs:
  - Push while full is dropped and sets the matching sticky flag.
  - Push while full in the same cycle as a pop is accepted.
  - Pop while empty is ignored.
  - RX FIFO entry width is DATA_BITS+2 (data, parity_err, frame_err).
  - clear_errors_i clears both sticky flags. A simultaneous new overflow wins (the flag stays 1).
- TX FSM, states IDLE, START, DATA, PARITY, STOP:
  - IDLE with the FIFO non-empty: pop the head and enter START next cycle.
  - Each state drives its bit for exactly D cycles (D = effective divider).
  - START drives 0; DATA drives bits LSB first.
  - PARITY is skipped when parity_bit_i=0. The parity bit makes the total count of ones (data+parity) even if parity_even_i=1, odd otherwise.
  - STOP drives 1 for D or 2D cycles.
  - Back-to-back words: the next START begins the cycle after STOP ends, with no idle gap.
- RX front end: 2-flop synchroniser on serial_i, then edge detect.
- RX FSM, states IDLE, START, DATA, PARITY, STOP:
  - IDLE: falling edge enters START.
  - START: sample at floor(D/2) cycles. If the sample is 1 (glitch), return to IDLE with no push.
  - DATA, PARITY and STOP: sample every D cycles from the start-bit sample.
  - STOP: the sample is taken and the word is pushed on the same cycle. frame_err = stop sample==0; parity_err = parity mismatch (0 if parity disabled).
  - After STOP: if the stop sample was 0, wait for the synchronised line to be high before re-arming. Otherwise return to IDLE immediately.
- ready_o rises 1 cycle after the push. Total latency from the serial_i stop-bit midpoint to ready_o is about 3 cycles (synchroniser + push).
- busy_o falls the cycle after the last stop bit completes with the FIFO empty.

Test Plan:
- DATA_BITS=8, divider=8, no parity, 1 stop: write 0xA5 -> serial_o is low 8 cycles, then bits 1,0,1,0,0,1,0,1 (8 cycles each), then high 8 cycles; busy_o drops afterwards.
- Loopback serial_o->serial_i, even parity, 2 stop bits: write 0x00, 0xFF, 0x3C back-to-back -> the RX FIFO holds the same three words with both error flags 0; ready_o=1 until 3 reads.
- Inject a frame 0x55 with stop bit forced 0 -> data_o=0x55, frame_err_o=1; the next valid frame 0x12 is received cleanly after the line returns high.
- Odd parity configured, frame sent with even parity -> parity_err_o=1 on that word only.
- Fill the RX FIFO (16 words), send a 17th -> rx_overrun_o=1 and the FIFO contents are unchanged. With the TX FIFO full, write while the TX pops -> accepted and no tx_overflow_o; clear_errors_i clears the flags.
- Assert reset_i mid-TX-frame and mid-RX-frame -> next cycle serial_o=1, ready_o=0, busy_o=0; a subsequent frame 0x81 transmits and receives correctly.

Source files
------------

// File: rtl/uart_buffered.sv
// Buffered full-duplex UART: TX/RX engines with a runtime baud divider, optional parity,
// one/two stop bits, and show-ahead FIFOs between the host registers and the serial pins.

module uart_buffered #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIVIDER_W  = 16
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [DIVIDER_W-1:0] clock_divider_i,
  input  logic                 two_stop_bits_i,
  input  logic                 parity_bit_i,
  input  logic                 parity_even_i,
  input  logic                 write_i,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic                 read_i,
  input  logic                 clear_errors_i,
  input  logic                 serial_i,
  output logic                 serial_o,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 ready_o,
  output logic                 tx_full_o,
  output logic                 busy_o,
  output logic                 tx_overflow_o,
  output logic                 rx_overrun_o
);
  // state    | meaning
  // S_IDLE   | line idle, waiting for a word (TX) or a falling edge (RX)
  // S_START  | start bit; RX samples it at mid-bit to reject glitches
  // S_DATA   | data bits, LSB first
  // S_PARITY | parity bit (only when enabled at frame start)
  // S_STOP   | stop bit(s); RX pushes the word at the stop sample
  // S_BREAK  | RX only: stop bit was 0, hold until the line returns high
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  localparam int CW = DIVIDER_W + 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int RW = DATA_BITS + 2;

  logic [DIVIDER_W-1:0] w_div;
  logic [CW-1:0]        w_div_m1;

  assign w_div    = (clock_divider_i < DIVIDER_W'(4)) ? DIVIDER_W'(4) : clock_divider_i;
  assign w_div_m1 = CW'(w_div) - CW'(1);

  // ---------------- TX path ----------------
  logic                 w_tx_empty, w_tx_full, w_tx_load, w_tx_drop;
  logic [DATA_BITS-1:0] w_tx_head;
  logic [2:0]           r_tx_state;
  logic [CW-1:0]        r_tx_cnt;
  logic [IW-1:0]        r_tx_idx;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic [DIVIDER_W-1:0] r_tx_div;
  logic                 r_tx_par_en, r_tx_two_stop, r_tx_par_bit;
  logic [CW-1:0]        w_tx_bit_m1, w_tx_stop_m1;

  // A word is taken from the FIFO from IDLE or on the last STOP cycle (no idle gap).
  assign w_tx_load    = !w_tx_empty &&
                        ((r_tx_state == S_IDLE) || ((r_tx_state == S_STOP) && (r_tx_cnt == '0)));
  assign w_tx_drop    = write_i && w_tx_full && !w_tx_load;
  assign w_tx_bit_m1  = CW'(r_tx_div) - CW'(1);
  assign w_tx_stop_m1 = r_tx_two_stop ? ((CW'(r_tx_div) << 1) - CW'(1)) : w_tx_bit_m1;

  uart_buffered_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .i_push  (write_i),
    .i_data  (data_i),
    .i_pop   (w_tx_load),
    .o_data  (w_tx_head),
    .o_empty (w_tx_empty),
    .o_full  (w_tx_full)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_tx_state    <= S_IDLE;
      r_tx_cnt      <= '0;
      r_tx_idx      <= '0;
      r_tx_shift    <= '0;
      r_tx_div      <= DIVIDER_W'(4);
      r_tx_par_en   <= 1'b0;
      r_tx_two_stop <= 1'b0;
      r_tx_par_bit  <= 1'b0;
    end else if (w_tx_load) begin
      r_tx_state    <= S_START;
      r_tx_cnt      <= w_div_m1;
      r_tx_idx      <= '0;
      r_tx_shift    <= w_tx_head;
      r_tx_div      <= w_div;
      r_tx_par_en   <= parity_bit_i;
      r_tx_two_stop <= two_stop_bits_i;
      r_tx_par_bit  <= (^w_tx_head) ^ ~parity_even_i;
    end else if (r_tx_state != S_IDLE) begin
      if (r_tx_cnt != '0) begin
        r_tx_cnt <= r_tx_cnt - CW'(1);
      end else begin
        r_tx_cnt <= w_tx_bit_m1;
        case (r_tx_state)
          S_START: r_tx_state <= S_DATA;
          S_DATA: begin
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_idx   <= r_tx_idx + IW'(1);
            if (r_tx_idx == IW'(DATA_BITS - 1)) begin
              if (r_tx_par_en) begin
                r_tx_state <= S_PARITY;
              end else begin
                r_tx_state <= S_STOP;
                r_tx_cnt   <= w_tx_stop_m1;
              end
            end
          end
          S_PARITY: begin
            r_tx_state <= S_STOP;
            r_tx_cnt   <= w_tx_stop_m1;
          end
          default: r_tx_state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    serial_o = 1'b1;
    case (r_tx_state)
      S_START:  serial_o = 1'b0;
      S_DATA:   serial_o = r_tx_shift[0];
      S_PARITY: serial_o = r_tx_par_bit;
      default:  serial_o = 1'b1;
    endcase
  end

  // ---------------- RX path ----------------
  logic                 r_rx_sync1, r_rx_sync2, r_rx_prev;
  logic                 w_rx_fall, w_rx_push, w_rx_pop, w_rx_drop;
  logic                 w_rx_empty, w_rx_full, w_rx_par_err, w_rx_frame_err;
  logic [RW-1:0]        w_rx_word, w_rx_head;
  logic [2:0]           r_rx_state;
  logic [CW-1:0]        r_rx_cnt;
  logic [IW-1:0]        r_rx_idx;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic [DIVIDER_W-1:0] r_rx_div;
  logic                 r_rx_par_en, r_rx_par_even, r_rx_par_bit;
  logic [CW-1:0]        w_rx_bit_m1;

  assign w_rx_fall      = r_rx_prev & ~r_rx_sync2;
  assign w_rx_bit_m1    = CW'(r_rx_div) - CW'(1);
  assign w_rx_push      = (r_rx_state == S_STOP) && (r_rx_cnt == '0);
  assign w_rx_pop       = read_i && !w_rx_empty;
  assign w_rx_drop      = w_rx_push && w_rx_full && !w_rx_pop;
  assign w_rx_par_err   = r_rx_par_en && (r_rx_par_bit != ((^r_rx_shift) ^ ~r_rx_par_even));
  assign w_rx_frame_err = ~r_rx_sync2;
  assign w_rx_word      = {r_rx_shift, w_rx_par_err, w_rx_frame_err};

  uart_buffered_fifo #(.WIDTH(RW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .i_push  (w_rx_push),
    .i_data  (w_rx_word),
    .i_pop   (read_i),
    .o_data  (w_rx_head),
    .o_empty (w_rx_empty),
    .o_full  (w_rx_full)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_rx_sync1    <= 1'b1;
      r_rx_sync2    <= 1'b1;
      r_rx_prev     <= 1'b1;
      r_rx_state    <= S_IDLE;
      r_rx_cnt      <= '0;
      r_rx_idx      <= '0;
      r_rx_shift    <= '0;
      r_rx_div      <= DIVIDER_W'(4);
      r_rx_par_en   <= 1'b0;
      r_rx_par_even <= 1'b0;
      r_rx_par_bit  <= 1'b0;
    end else begin
      r_rx_sync1 <= serial_i;
      r_rx_sync2 <= r_rx_sync1;
      r_rx_prev  <= r_rx_sync2;
      case (r_rx_state)
        S_IDLE: begin
          if (w_rx_fall) begin
            r_rx_state    <= S_START;
            r_rx_cnt      <= CW'(w_div >> 1) - CW'(1);
            r_rx_idx      <= '0;
            r_rx_div      <= w_div;
            r_rx_par_en   <= parity_bit_i;
            r_rx_par_even <= parity_even_i;
          end
        end
        S_BREAK: begin
          if (r_rx_sync2) r_rx_state <= S_IDLE;
        end
        default: begin
          if (r_rx_cnt != '0) begin
            r_rx_cnt <= r_rx_cnt - CW'(1);
          end else begin
            r_rx_cnt <= w_rx_bit_m1;
            case (r_rx_state)
              S_START: r_rx_state <= r_rx_sync2 ? S_IDLE : S_DATA;
              S_DATA: begin
                r_rx_shift <= {r_rx_sync2, r_rx_shift[DATA_BITS-1:1]};
                r_rx_idx   <= r_rx_idx + IW'(1);
                if (r_rx_idx == IW'(DATA_BITS - 1))
                  r_rx_state <= r_rx_par_en ? S_PARITY : S_STOP;
              end
              S_PARITY: begin
                r_rx_par_bit <= r_rx_sync2;
                r_rx_state   <= S_STOP;
              end
              default: r_rx_state <= r_rx_sync2 ? S_IDLE : S_BREAK;
            endcase
          end
        end
      endcase
    end
  end

  // ---------------- sticky flags and outputs ----------------
  logic r_tx_overflow, r_rx_overrun;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_tx_overflow <= 1'b0;
      r_rx_overrun  <= 1'b0;
    end else begin
      r_tx_overflow <= w_tx_drop | (r_tx_overflow & ~clear_errors_i);
      r_rx_overrun  <= w_rx_drop | (r_rx_overrun & ~clear_errors_i);
    end
  end

  assign data_o        = w_rx_head[RW-1:2];
  assign parity_err_o  = w_rx_head[1];
  assign frame_err_o   = w_rx_head[0];
  assign ready_o       = !w_rx_empty;
  assign tx_full_o     = w_tx_full;
  assign busy_o        = !w_tx_empty || (r_tx_state != S_IDLE);
  assign tx_overflow_o = r_tx_overflow;
  assign rx_overrun_o  = r_rx_overrun;

endmodule

// Show-ahead FIFO; a push while full is accepted only when a pop happens in the same cycle.
module uart_buffered_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok, w_pop_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clock_i) begin
    if (!reset_i && w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push_ok && !w_pop_ok)      r_count <= r_count + (AW+1)'(1);
      else if (!w_push_ok && w_pop_ok) r_count <= r_count - (AW+1)'(1);
    end
  end

endmodule

// File: tb/tb_uart_buffered.sv
// Directed bench for uart_buffered: TX waveform, loopback, framing/parity errors,
// FIFO overflow/overrun with sticky-flag clearing, and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_buffered;
  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [15:0] div = 16'd8;
  logic        two_stop = 1'b0, par_en = 1'b0, par_even = 1'b0;
  logic        write = 1'b0, read = 1'b0, clr = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        loop_en = 1'b0, drv_line = 1'b1;
  logic        serial_i, serial_o, parity_err_o, frame_err_o, ready_o;
  logic        tx_full_o, busy_o, tx_overflow_o, rx_overrun_o;
  logic [7:0]  data_o;
  int          n_pass = 0, n_total = 0;

  assign serial_i = loop_en ? serial_o : drv_line;

  uart_buffered #(.DATA_BITS(8), .FIFO_DEPTH(16), .DIVIDER_W(16)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .clock_divider_i(div),
    .two_stop_bits_i(two_stop), .parity_bit_i(par_en), .parity_even_i(par_even),
    .write_i(write), .data_i(din), .read_i(read), .clear_errors_i(clr),
    .serial_i(serial_i), .serial_o(serial_o), .data_o(data_o),
    .parity_err_o(parity_err_o), .frame_err_o(frame_err_o), .ready_o(ready_o),
    .tx_full_o(tx_full_o), .busy_o(busy_o), .tx_overflow_o(tx_overflow_o),
    .rx_overrun_o(rx_overrun_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock_i);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic write_word(input logic [7:0] d);
    din = d; write = 1'b1; tick(); write = 1'b0;
  endtask

  task automatic pop();
    read = 1'b1; tick(); read = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    drv_line = b; tick(8);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (pe) send_bit(pb);
    send_bit(stop);
    drv_line = 1'b1;
  endtask

  task automatic check_rx(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    check({tag, "_ready"}, ready_o, 1);
    check({tag, "_data"}, data_o, d);
    check({tag, "_perr"}, parity_err_o, pe);
    check({tag, "_ferr"}, frame_err_o, fe);
  endtask

  initial begin
    logic [7:0] pat;
    logic       exp_bit;

    // reset state
    tick(3);
    reset_i = 1'b0;
    tick();
    check("rst_serial", serial_o, 1);
    check("rst_data", data_o, 0);
    check("rst_ready", ready_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_full", tx_full_o, 0);
    check("rst_flags", {tx_overflow_o, rx_overrun_o, parity_err_o, frame_err_o}, 0);

    // TX waveform of 0xA5, D=8, 8N1
    pat = 8'hA5;
    write_word(pat);
    check("a5_busy_pre", busy_o, 1);
    check("a5_line_pre", serial_o, 1);
    tick();
    for (int k = 0; k < 80; k++) begin
      if (k < 8) exp_bit = 1'b0;
      else if (k >= 72) exp_bit = 1'b1;
      else exp_bit = pat[(k / 8) - 1];
      check("a5_bit", serial_o, exp_bit);
      tick();
    end
    check("a5_busy_post", busy_o, 0);
    check("a5_line_post", serial_o, 1);

    // divider 2 clamps to 4; divider change mid-frame is ignored
    div = 16'd2;
    write_word(8'h01);
    tick();
    div = 16'd8;
    for (int k = 0; k < 12; k++) begin
      check("clamp_bit", serial_o, (k >= 4 && k < 8) ? 1 : 0);
      tick();
    end
    tick(30);
    check("clamp_idle", busy_o, 0);

    // loopback, even parity, two stop bits
    loop_en = 1'b1; par_en = 1'b1; par_even = 1'b1; two_stop = 1'b1;
    write_word(8'h00);
    write_word(8'hFF);
    write_word(8'h3C);
    tick(400);
    check_rx("lb0", 8'h00, 0, 0); pop();
    check_rx("lb1", 8'hFF, 0, 0); pop();
    check_rx("lb2", 8'h3C, 0, 0); pop();
    check("lb_empty", ready_o, 0);
    loop_en = 1'b0; par_en = 1'b0; par_even = 1'b0; two_stop = 1'b0;

    // framing error then clean frame
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    tick(16);
    check_rx("ferr", 8'h55, 0, 1); pop();
    check("ferr_empty", ready_o, 0);
    send_frame(8'h12, 1'b0, 1'b0, 1'b1);
    tick(16);
    check_rx("after_ferr", 8'h12, 0, 0); pop();

    // odd parity configured: first frame carries even parity, second is correct
    par_en = 1'b1; par_even = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    tick(16);
    send_frame(8'h03, 1'b1, 1'b1, 1'b1);
    tick(16);
    check_rx("perr_bad", 8'h07, 1, 0); pop();
    check_rx("perr_good", 8'h03, 0, 0); pop();
    check("perr_empty", ready_o, 0);
    par_en = 1'b0;

    // RX overrun: 17 words into a 16-deep RX FIFO
    loop_en = 1'b1;
    for (int i = 0; i < 17; i++) write_word(8'h10 + 8'(i));
    tick(1500);
    check("ovr_flag", rx_overrun_o, 1);
    check("ovr_txflag", tx_overflow_o, 0);
    for (int i = 0; i < 16; i++) begin
      check("ovr_data", data_o, 8'h10 + 8'(i));
      pop();
    end
    check("ovr_empty", ready_o, 0);

    // TX FIFO full: first write popped one cycle later, 16 more fill the FIFO
    for (int i = 0; i < 17; i++) write_word(8'h40 + 8'(i));
    check("txf_full", tx_full_o, 1);
    din = 8'hEE; write = 1'b1; clr = 1'b1;
    tick();
    write = 1'b0; clr = 1'b0;
    check("txf_ovf_wins", tx_overflow_o, 1);
    check("txf_rx_cleared", rx_overrun_o, 0);
    clr = 1'b1; tick(); clr = 1'b0;
    check("txf_clear", tx_overflow_o, 0);
    tick(62);
    check("txf_still_full", tx_full_o, 1);
    // this edge is the last STOP cycle of the first word: pop and push coincide
    din = 8'h77; write = 1'b1; tick(); write = 1'b0;
    check("txf_no_ovf", tx_overflow_o, 0);
    check("txf_full_after", tx_full_o, 1);
    check("txf_next_start", serial_o, 0);

    // reset mid TX and mid RX frame
    tick(20);
    check("mid_ready", ready_o, 1);
    check("mid_busy", busy_o, 1);
    reset_i = 1'b1;
    tick();
    check("mrst_serial", serial_o, 1);
    check("mrst_ready", ready_o, 0);
    check("mrst_busy", busy_o, 0);
    check("mrst_full", tx_full_o, 0);
    check("mrst_data", data_o, 0);
    reset_i = 1'b0;
    tick();
    write_word(8'h81);
    tick(120);
    check_rx("post_rst", 8'h81, 0, 0);
    check("post_rst_busy", busy_o, 0);
    check("post_rst_line", serial_o, 1);
    pop();
    check("post_rst_empty", ready_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
